ps2_key_ctrl: RTL and testbench
===============================

# ps2_key_ctrl

Scan-code sequencer between the PS/2 byte receiver and the STG game logic. It consumes one-cycle byte strobes from the receiver and runs the PS/2 Set 2 prefix state machine (E0 extended, F0 break). It maintains a held-key vector for the eight game actions and queues press/release events in a small first-word-fall-through FIFO with a valid/ready handshake. A timeout recovers the decoder from truncated prefix sequences.

## Interface
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 2_000_000: idle cycles (20 ms at 100 MHz) after which a pending prefix is discarded.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- code_valid  in  1  one-cycle strobe: code_byte holds a new received scan byte
- code_byte  in  8  scan byte from receiver
- keys_held  out  8  [0]up [1]down [2]left [3]right [4]fire [5]bomb [6]slow [7]pause; 1 = held
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_key  out  3  action index (bit position in keys_held) of head event
- evt_press  out  1  1 = press, 0 = release
- evt_overflow  out  1  sticky: an event was dropped on a full FIFO
- ovf_clr  in  1  clears evt_overflow

## Operation
- Key map, plain codes:
  - 1D→0, 1B→1, 1C→2, 23→3
  - 3B→4 (J), 42→5 (K), 12→6 (LShift), 76→7 (Esc)
- Key map, extended (E0-prefixed):
  - 75→0, 72→1, 6B→2, 74→3
  - All other extended codes are unmapped.
- WASD and arrows alias to the same bit. Releasing either clears it.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Each code_valid is handled as follows.
  - IDLE: E0→EXT; F0→BRK; mapped plain code→press; anything else (E1, AA, FA, FE, unmapped)→stays IDLE, no action.
  - EXT: F0→EXT_BRK; E0→EXT; mapped extended code→press, then IDLE; other→IDLE.
  - BRK: mapped plain code→release, then IDLE; other→IDLE.
  - EXT_BRK: mapped extended code→release, then IDLE; other→IDLE.
- Press on bit k:
  - If keys_held[k]=0: set the bit and push {k,1}.
  - If already 1 (typematic repeat): no change, no push.
- Release on bit k:
  - If keys_held[k]=1: clear the bit and push {k,0}.
  - If already 0: no change, no push.
- Push into a full FIFO:
  - The event is dropped and evt_overflow is set.
  - keys_held still updates.
  - Exception: if a pop occurs in the same cycle, the push is accepted.
- evt_overflow stays at 1 until ovf_clr=1 for a cycle. If a drop and ovf_clr coincide, the drop wins and evt_overflow stays 1.
- Timeout: a counter runs while the FSM is not in IDLE and resets on every code_valid. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE with no action. The counter saturates and never wraps.
- Reset (rst_n low, at any time, including mid-prefix):
  - FSM to IDLE; timeout counter cleared; FIFO emptied.
  - keys_held=0, evt_valid=0, evt_key=0, evt_press=0, evt_overflow=0.

## Timing
- All outputs are registered.
- code_valid at edge N: keys_held and the FSM state are updated at N+1.
- An event pushed into an empty FIFO appears with evt_valid=1 at N+1 (one-cycle latency).
- A handshake at edge M advances the head at M+1. evt_valid drops at M+1 if the FIFO is then empty.
- evt_key and evt_press are stable while evt_valid=1 and evt_ready=0.
- One code byte is processed per cycle; back-to-back code_valid strobes are legal.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.

## Test plan
- Reset, then bytes 1D, F0, 1D with evt_ready=1 → keys_held goes 01 then 00; events {0,1} then {0,0}; evt_overflow=0.
- Extended arrow: E0, 74, E0, F0, 74 → keys_held[3] is set then cleared; exactly 2 events, with FSM states EXT, IDLE, EXT, EXT_BRK, IDLE.
- Typematic: 3B ×5 then F0, 3B → exactly 2 events ({4,1}, {4,0}); keys_held[4] held through all repeats.
- Overflow with FIFO_DEPTH=4 and evt_ready=0: press 1D, 1B, 1C, 23, 3B →
  - keys_held=1F; FIFO holds 4 events; evt_overflow=1.
  - Draining yields keys 0, 1, 2, 3 in order; ovf_clr returns evt_overflow to 0.
- Timeout (TIMEOUT_CYCLES=16): send F0, wait 20 cycles, then 1D → treated as a press (keys_held[0]=1), not a release.
- Reset mid-operation: send E0, F0, deassert rst_n for 1 cycle, then 6B →
  - All outputs are 0 after reset.
  - 6B is unmapped as a plain code, so no event and keys_held=00.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 Set 2 scan-code sequencer for the STG game logic.
// Decodes E0 (extended) and F0 (break) prefixes, keeps a held-key vector for
// eight game actions and queues press/release events in a first-word-fall-
// through FIFO with a valid/ready handshake. A pending prefix is dropped after
// TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   code_valid_i        one-cycle strobe, code_byte_i holds a new scan byte
//   code_byte_i[7:0]    scan byte from the receiver
//   keys_held_o[7:0]    [0]up [1]down [2]left [3]right [4]fire [5]bomb [6]slow [7]pause
//   evt_valid_o         FIFO head valid
//   evt_ready_i         consumer accepts head when evt_valid_o & evt_ready_i
//   evt_key_o[2:0]      action index of the head event
//   evt_press_o         1 = press, 0 = release
//   evt_overflow_o      sticky: an event was dropped on a full FIFO
//   ovf_clr_i           clears evt_overflow_o
//
// State | Meaning
// ------+-------------------------------------------
// IDLE  | no prefix pending
// EXT   | E0 seen, waiting for extended code or F0
// BRK   | F0 seen, next plain code is a release
// EXT_BRK | E0 F0 seen, next extended code is a release
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       code_valid_i,
    input  logic [7:0] code_byte_i,
    output logic [7:0] keys_held_o,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [2:0] evt_key_o,
    output logic       evt_press_o,
    output logic       evt_overflow_o,
    input  logic       ovf_clr_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    held_q, held_d;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic       plain_hit, ext_hit;
    logic [2:0] plain_idx, ext_idx;
    logic       act_press, act_release;
    logic [2:0] act_idx;
    logic       push, push_press, push_ok, pop, full, drop;

    always_comb begin
        plain_hit = 1'b1;
        plain_idx = 3'd0;
        case (code_byte_i)
            8'h1D:   plain_idx = 3'd0;
            8'h1B:   plain_idx = 3'd1;
            8'h1C:   plain_idx = 3'd2;
            8'h23:   plain_idx = 3'd3;
            8'h3B:   plain_idx = 3'd4;
            8'h42:   plain_idx = 3'd5;
            8'h12:   plain_idx = 3'd6;
            8'h76:   plain_idx = 3'd7;
            default: plain_hit = 1'b0;
        endcase
        ext_hit = 1'b1;
        ext_idx = 3'd0;
        case (code_byte_i)
            8'h75:   ext_idx = 3'd0;
            8'h72:   ext_idx = 3'd1;
            8'h6B:   ext_idx = 3'd2;
            8'h74:   ext_idx = 3'd3;
            default: ext_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        act_press   = 1'b0;
        act_release = 1'b0;
        act_idx     = plain_idx;
        if (code_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (code_byte_i == 8'hE0)      state_d = ST_EXT;
                    else if (code_byte_i == 8'hF0) state_d = ST_BRK;
                    else                           act_press = plain_hit;
                end
                ST_EXT: begin
                    if (code_byte_i == 8'hF0)      state_d = ST_EXT_BRK;
                    else if (code_byte_i == 8'hE0) state_d = ST_EXT;
                    else begin
                        state_d   = ST_IDLE;
                        act_press = ext_hit;
                        act_idx   = ext_idx;
                    end
                end
                ST_BRK: begin
                    state_d     = ST_IDLE;
                    act_release = plain_hit;
                end
                ST_EXT_BRK: begin
                    state_d     = ST_IDLE;
                    act_release = ext_hit;
                    act_idx     = ext_idx;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TO_MAX) begin
            state_d = ST_IDLE;
        end
    end

    // Counter only runs while a prefix is pending; it saturates at TO_MAX.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (code_valid_i || state_q == ST_IDLE) to_cnt_d = '0;
        else if (to_cnt_q != TO_MAX)            to_cnt_d = to_cnt_q + TW'(1);
    end

    // Only edges of the held vector generate events; typematic repeats and
    // releases of keys not held are swallowed here.
    always_comb begin
        held_d     = held_q;
        push       = 1'b0;
        push_press = 1'b0;
        if (act_press && !held_q[act_idx]) begin
            held_d[act_idx] = 1'b1;
            push            = 1'b1;
            push_press      = 1'b1;
        end
        if (act_release && held_q[act_idx]) begin
            held_d[act_idx] = 1'b0;
            push            = 1'b1;
        end
    end

    // A simultaneous pop frees a slot, so a push into a full FIFO still fits.
    always_comb begin
        pop     = (cnt_q != '0) && evt_ready_i;
        full    = (cnt_q == DEPTH_C);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
        wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop)           ovf_d = 1'b1;
        else if (ovf_clr_i) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            held_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            held_q   <= held_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (push_ok) mem_q[wptr_q] <= {act_idx, push_press};
        end
    end

    assign keys_held_o    = held_q;
    assign evt_valid_o    = (cnt_q != '0);
    assign evt_key_o      = mem_q[rptr_q][3:1];
    assign evt_press_o    = mem_q[rptr_q][0];
    assign evt_overflow_o = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_byte = 8'h00;
    logic [7:0] keys_held;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] evt_key;
    logic       evt_press;
    logic       evt_overflow;
    logic       ovf_clr = 1'b0;

    ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .code_valid_i(code_valid), .code_byte_i(code_byte),
        .keys_held_o(keys_held), .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
        .evt_key_o(evt_key), .evt_press_o(evt_press), .evt_overflow_o(evt_overflow),
        .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int dut_pops = 0;

    // Reference model: prefix flags, held set, event queue, sticky overflow.
    bit         m_ext, m_brk;
    int         m_idle;
    logic [7:0] m_held;
    logic [3:0] mq[$];
    logic       m_ovf;

    function automatic int lookup(input logic [7:0] b, input bit ext);
        logic [7:0] pl[8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B, 8'h42, 8'h12, 8'h76};
        logic [7:0] ex[4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
        if (ext) begin
            for (int i = 0; i < 4; i++) if (ex[i] == b) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (pl[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0; m_held = '0; m_ovf = 0;
        mq.delete();
    endtask

    task automatic compare_all();
        chk("keys_held", 32'(keys_held), 32'(m_held));
        chk("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
        chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            chk("evt_key", 32'(evt_key), 32'(mq[0][3:1]));
            chk("evt_press", 32'(evt_press), 32'(mq[0][0]));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic clr);
        bit         pop, push, drop;
        logic [3:0] ev;
        int         k;
        @(negedge clk);
        code_valid = v; code_byte = b; evt_ready = rdy; ovf_clr = clr;
        if (evt_valid && rdy) dut_pops++;
        pop  = (mq.size() > 0) && rdy;
        push = 0;
        ev   = '0;
        if (v) begin
            m_idle = 0;
            if (b == 8'hE0 && !m_brk)      m_ext = 1;
            else if (b == 8'hF0 && !m_brk) m_brk = 1;
            else begin
                k = lookup(b, m_ext);
                if (k >= 0) begin
                    if (!m_brk && !m_held[k]) begin
                        m_held[k] = 1'b1; push = 1; ev = {3'(k), 1'b1};
                    end else if (m_brk && m_held[k]) begin
                        m_held[k] = 1'b0; push = 1; ev = {3'(k), 1'b0};
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle > TMO) begin
                m_ext = 0; m_brk = 0; m_idle = 0;
            end
        end
        drop = push && (mq.size() == DEPTH) && !pop;
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (pop) void'(mq.pop_front());
        if (push && !drop) mq.push_back(ev);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; code_valid = 0; code_byte = 0; evt_ready = 0; ovf_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_keys", 32'(keys_held), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_key", 32'(evt_key), 32'h0);
        chk("rst_press", 32'(evt_press), 32'h0);
        chk("rst_ovf", 32'(evt_overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int p0, r, gap;
        logic [7:0] pool_pl[8] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B, 8'h42, 8'h12, 8'h76};
        logic [7:0] pool_ex[5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h7D};
        logic [7:0] pool_sp[4] = '{8'hE1, 8'hAA, 8'hFA, 8'hFE};
        logic [7:0] b;
        model_reset();
        do_reset();

        // Plain press/release
        step(1, 8'h1D, 1, 0);
        chk("t1_press_keys", 32'(keys_held), 32'h01);
        chk("t1_press_evt", 32'({evt_valid, evt_key, evt_press}), 32'b1_000_1);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h1D, 1, 0);
        chk("t1_rel_keys", 32'(keys_held), 32'h00);
        chk("t1_rel_evt", 32'({evt_valid, evt_key, evt_press}), 32'b1_000_0);
        step(0, 8'h00, 1, 0);
        chk("t1_ovf", 32'(evt_overflow), 32'h0);

        // Extended arrow
        p0 = dut_pops;
        step(1, 8'hE0, 1, 0);
        step(1, 8'h74, 1, 0);
        chk("t2_held", 32'(keys_held[3]), 32'h1);
        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h74, 1, 0);
        chk("t2_clear", 32'(keys_held[3]), 32'h0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t2_events", 32'(dut_pops - p0), 32'd2);

        // Typematic repeat
        p0 = dut_pops;
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h3B, 1, 0);
            chk("t3_hold", 32'(keys_held[4]), 32'h1);
        end
        step(1, 8'hF0, 1, 0);
        step(1, 8'h3B, 1, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("t3_events", 32'(dut_pops - p0), 32'd2);

        // Overflow
        step(1, 8'h1D, 0, 0);
        step(1, 8'h1B, 0, 0);
        step(1, 8'h1C, 0, 0);
        step(1, 8'h23, 0, 0);
        step(1, 8'h3B, 0, 0);
        chk("t4_keys", 32'(keys_held), 32'h1F);
        chk("t4_ovf", 32'(evt_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_key", 32'(evt_key), 32'(i));
            step(0, 8'h00, 1, 0);
        end
        chk("t4_empty", 32'(evt_valid), 32'h0);
        chk("t4_ovf_kept", 32'(evt_overflow), 32'h1);
        step(0, 8'h00, 0, 1);
        chk("t4_ovf_clr", 32'(evt_overflow), 32'h0);

        // Timeout
        do_reset();
        step(1, 8'hF0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h1D, 1, 0);
        chk("t5_press", 32'(keys_held[0]), 32'h1);

        // Reset mid-prefix
        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 1, 0);
        do_reset();
        step(1, 8'h6B, 1, 0);
        chk("t6_keys", 32'(keys_held), 32'h00);
        chk("t6_valid", 32'(evt_valid), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: b = pool_pl[$urandom_range(0, 7)];
                4:          b = pool_ex[$urandom_range(0, 4)];
                5, 6:       b = 8'hE0;
                7:          b = 8'hF0;
                8:          b = 8'($urandom);
                default:    b = pool_sp[$urandom_range(0, 3)];
            endcase
            step(logic'($urandom_range(0, 1)), b, logic'($urandom_range(0, 2) != 0),
                 logic'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 39) == 0) begin
                gap = $urandom_range(10, 25);
                for (int g = 0; g < gap; g++)
                    step(0, 8'h00, logic'($urandom_range(0, 1)), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
